// File: rtl/span_position_loader.sv
// span_position_loader
//   Upstream stage of the scanning-risk calculator. Accumulates signed trade
//   quantities into one net position for each contract month and, on each
//   batch close, publishes a stable snapshot with a valid/ack handshake. The
//   next batch accumulates while the previous snapshot is still pending, so
//   the loader is double-buffered.
//
// Ports
//   i_clk            clock, rising edge
//   i_reset          asynchronous active-low reset
//   i_clear          synchronous abort of the batch in progress
//   i_trade_valid    a trade is presented
//   o_trade_ready    a trade can be accepted this cycle
//   i_trade_month    target month index
//   i_trade_qty      signed quantity (positive = long)
//   i_trade_last     this trade closes the batch
//   o_position       snapshot positions, one per month
//   o_pos_sat        per-month flag: month saturated during the snapshot's batch
//   o_batch_trades   number of trades in the snapshot
//   o_pos_valid      snapshot valid and held stable
//   i_pos_ack        consumer has taken the snapshot
module span_position_loader #(
    parameter int NUM_MONTHS = 8,
    parameter int POS_W      = 16,
    parameter int CNT_W      = 16,
    localparam int MW        = (NUM_MONTHS > 1) ? $clog2(NUM_MONTHS) : 1
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic                                i_clear,
    input  logic                                i_trade_valid,
    output logic                                o_trade_ready,
    input  logic [MW-1:0]                       i_trade_month,
    input  logic [POS_W-1:0]                    i_trade_qty,
    input  logic                                i_trade_last,
    output logic [NUM_MONTHS-1:0][POS_W-1:0]    o_position,
    output logic [NUM_MONTHS-1:0]               o_pos_sat,
    output logic [CNT_W-1:0]                    o_batch_trades,
    output logic                                o_pos_valid,
    input  logic                                i_pos_ack
);

    typedef enum logic {ST_ACCUM, ST_STALL} state_t;

    localparam logic [POS_W-1:0] P_MAX = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic [POS_W-1:0] P_MIN = {1'b1, {(POS_W-1){1'b0}}};

    state_t                             r_state;
    state_t                             w_state_nxt;

    logic [NUM_MONTHS-1:0][POS_W-1:0]   r_acc;
    logic [NUM_MONTHS-1:0]              r_sat_acc;
    logic [CNT_W-1:0]                   r_cnt;
    logic [NUM_MONTHS-1:0][POS_W-1:0]   r_position;
    logic [NUM_MONTHS-1:0]              r_pos_sat;
    logic [CNT_W-1:0]                   r_batch_trades;
    logic                               r_pos_valid;

    logic                               w_ready;
    logic                               w_accept;
    logic                               w_close;
    logic                               w_xfer;
    logic [NUM_MONTHS-1:0][POS_W:0]     w_sum;
    logic [NUM_MONTHS-1:0][POS_W-1:0]   w_acc_nxt;
    logic [NUM_MONTHS-1:0]              w_sat_nxt;
    logic [CNT_W-1:0]                   w_cnt_nxt;

    assign w_accept = i_trade_valid & w_ready;
    assign w_close  = w_accept & i_trade_last;
    // A snapshot moves to the outputs either on a closing trade when the
    // output slot is free (or being freed this cycle), or when a held batch
    // in STALL is released by the ack. Clear discards a held batch.
    assign w_xfer   = (w_close & (~r_pos_valid | i_pos_ack))
                    | ((r_state == ST_STALL) & i_pos_ack & ~i_clear);

    // Accumulator update with signed saturation; an out-of-range month
    // index matches no accumulator but is still counted.
    always_comb begin
        w_sum     = '0;
        w_acc_nxt = r_acc;
        w_sat_nxt = r_sat_acc;
        for (int unsigned m = 0; m < NUM_MONTHS; m++) begin
            w_sum[m] = {r_acc[m][POS_W-1], r_acc[m]}
                     + {i_trade_qty[POS_W-1], i_trade_qty};
            if (w_accept && (i_trade_month == MW'(m))) begin
                if (w_sum[m][POS_W] != w_sum[m][POS_W-1]) begin
                    w_acc_nxt[m] = w_sum[m][POS_W] ? P_MIN : P_MAX;
                    w_sat_nxt[m] = 1'b1;
                end else begin
                    w_acc_nxt[m] = w_sum[m][POS_W-1:0];
                end
            end
        end
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_accept && (r_cnt != '1)) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    // FSM: state register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        if (i_clear) begin
            w_state_nxt = ST_ACCUM;
        end else begin
            case (r_state)
                ST_ACCUM: if (w_close && r_pos_valid && !i_pos_ack) w_state_nxt = ST_STALL;
                ST_STALL: if (i_pos_ack) w_state_nxt = ST_ACCUM;
                default:  w_state_nxt = ST_ACCUM;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        w_ready = (r_state == ST_ACCUM) & ~i_clear & i_reset;
    end

    // Accumulators and published snapshot
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_acc          <= '0;
            r_sat_acc      <= '0;
            r_cnt          <= '0;
            r_position     <= '0;
            r_pos_sat      <= '0;
            r_batch_trades <= '0;
            r_pos_valid    <= 1'b0;
        end else begin
            if (i_clear || w_xfer) begin
                r_acc     <= '0;
                r_sat_acc <= '0;
                r_cnt     <= '0;
            end else begin
                r_acc     <= w_acc_nxt;
                r_sat_acc <= w_sat_nxt;
                r_cnt     <= w_cnt_nxt;
            end

            if (w_xfer) begin
                r_position     <= w_acc_nxt;
                r_pos_sat      <= w_sat_nxt;
                r_batch_trades <= w_cnt_nxt;
                r_pos_valid    <= 1'b1;
            end else if (i_pos_ack && r_pos_valid) begin
                r_pos_valid    <= 1'b0;
            end
        end
    end

    assign o_trade_ready  = w_ready;
    assign o_position     = r_position;
    assign o_pos_sat      = r_pos_sat;
    assign o_batch_trades = r_batch_trades;
    assign o_pos_valid    = r_pos_valid;

endmodule

// File: doc/span_position_loader.md
Name: span_position_loader

Overview:
Upstream stage of the scanning-risk calculator. Accepts a stream of signed trade quantities tagged with a contract-month index and accumulates a net position per month. On each batch close it publishes a stable snapshot of the eight per-month positions to the scanning-risk stage, together with a valid/ack handshake. Accumulation of the next batch overlaps with the pending snapshot, so the loader is double-buffered.

Parameters:
NUM_MONTHS, 8, number of contract months; also the number of position outputs.
POS_W, 16, width of each position in bits (signed two's complement).
CNT_W, 16, width of the per-batch trade counter.

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-low reset.
clear  in  1  synchronous abort of the batch in progress.
trade_valid  in  1  a trade is presented.
trade_ready  out  1  the loader can accept a trade this cycle.
trade_month  in  $clog2(NUM_MONTHS)  target month index.
trade_qty  in  POS_W  signed quantity (positive = long).
trade_last  in  1  this trade closes the batch.
position  out  NUM_MONTHS x POS_W  snapshot positions, feeds the scanning-risk stage.
pos_sat  out  NUM_MONTHS  per-month flag: the month saturated during the snapshot's batch.
batch_trades  out  CNT_W  number of trades in the snapshot.
pos_valid  out  1  the snapshot is valid and held stable.
pos_ack  in  1  the consumer has taken the snapshot.

Behaviour:
- Internal state: acc[NUM_MONTHS], sat_acc[NUM_MONTHS], cnt (CNT_W) and an FSM with two states, ACCUM and STALL.
- Reset (reset=0, asynchronous):
  - acc, sat_acc, cnt, position, pos_sat, batch_trades and pos_valid all go to 0.
  - FSM goes to ACCUM.
  - trade_ready=0 while reset is asserted.
- trade_ready is combinational: it is 1 only when state=ACCUM and clear=0 and reset=1.
- A trade is accepted when trade_valid & trade_ready.
- Accept, month m:
  - acc[m] <= acc[m] + trade_qty with signed saturation to [-2^(POS_W-1), 2^(POS_W-1)-1]; that is [-32768, 32767] at the defaults.
  - If saturation occurs, sat_acc[m] <= 1.
  - cnt <= cnt+1, saturating at 2^CNT_W-1.
  - Any trade_month >= NUM_MONTHS: the trade is accepted and counted, but no accumulator changes.
- Batch close (accept with trade_last=1), using the values that include this trade:
  - If pos_valid=0, or pos_ack=1 in the same cycle:
    - position <= acc, pos_sat <= sat_acc, batch_trades <= cnt.
    - acc, sat_acc and cnt are cleared.
    - pos_valid <= 1.
    - Snapshot latency is 1 cycle after the closing trade is accepted.
  - Otherwise (pos_valid=1 and pos_ack=0): acc keeps the updated values and the FSM goes to STALL.
- STALL:
  - trade_ready=0.
  - On pos_ack=1: the held batch transfers to the outputs, acc/sat_acc/cnt are cleared, pos_valid stays 1 (the new snapshot), and the FSM returns to ACCUM.
- pos_ack with pos_valid=1 and no transfer in that cycle: pos_valid <= 0; position keeps its last value.
- pos_ack with pos_valid=0: ignored.
- position, pos_sat and batch_trades change only on a snapshot transfer or reset. They are never modified while pos_valid=1 unless pos_ack=1 in the same cycle.
- clear=1:
  - acc, sat_acc and cnt are zeroed and the FSM goes to ACCUM.
  - trade_ready=0, so no trade is accepted in that cycle.
  - position and pos_valid are unaffected.
  - If clear arrives in STALL, the held batch is discarded.
- Empty batch: a closing trade with qty=0 publishes the current acc; batch_trades >= 1.

Test Plan:
1. Reset, then accept (m0,+5), (m0,-2), (m3,+100, last) -> one cycle later pos_valid=1, position[0]=3, position[3]=100, others 0, batch_trades=3, pos_sat=0.
2. With pos_valid=1 and no ack, stream (m1,+7),(m1,+1,last) -> FSM enters STALL, trade_ready=0, position unchanged. Pulse pos_ack -> next cycle position[1]=8, pos_valid=1, trade_ready=1.
3. Accumulate (m2,+30000),(m2,+30000),(m2,-1,last) -> position[2]=32766, pos_sat[2]=1. Accumulate (m5,-32768),(m5,-1,last) -> position[5]=-32768, pos_sat[5]=1.
4. Accept a closing trade with pos_ack=1 in the same cycle while pos_valid=1 -> no STALL; the new snapshot appears next cycle and pos_valid stays 1.
5. Accept (m4,+9), assert clear for 1 cycle, then (m4,+1,last) -> position[4]=1, batch_trades=1. Check trade_ready=0 in the clear cycle.
6. Assert reset mid-batch and in STALL -> all outputs 0 immediately (asynchronous), trade_ready=0; after release, ACCUM with trade_ready=1.
